ft232h_rx: RTL and testbench



---
 rtl/ft232h_pkg.sv | 12 +
 rtl/axis_io.sv | 14 +
 rtl/ft232h_skid_fifo.sv | 54 +++++
 rtl/ft232h_rx.sv | 129 ++++++++++++
 tb/tb_ft232h_rx.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ft232h_pkg.sv
// Shared types and constants for the FT232H synchronous 245 FIFO blocks.
package ft232h_pkg;

    localparam int unsigned FTDI_DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TURN = 2'd1,
        READ = 2'd2
    } ftdi_rx_state_t;

endpackage

// File: rtl/axis_io.sv
// Minimal AXI-Stream bundle: tdata/tvalid/tready/tlast.
interface axis_io #(
    parameter int unsigned W = 8
) ();

    logic [W-1:0] tdata;
    logic         tvalid;
    logic         tready;
    logic         tlast;

    modport Source (output tdata, output tvalid, output tlast, input tready);
    modport Sink   (input tdata, input tvalid, input tlast, output tready);

endinterface

// File: rtl/ft232h_skid_fifo.sv
// Small first-word-fall-through circular FIFO with wrap-bit pointers.
// A push into a full FIFO is accepted only when a pop frees the slot in the
// same cycle; otherwise it is dropped.
module ft232h_skid_fifo #(
    parameter int unsigned SKID_DEPTH = 4,
    parameter int unsigned WIDTH      = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        push,
    input  logic [WIDTH-1:0]            push_data,
    input  logic                        pop,
    output logic [WIDTH-1:0]            pop_data,
    output logic                        full,
    output logic                        empty,
    output logic [$clog2(SKID_DEPTH):0] count
);

    localparam int unsigned AW = $clog2(SKID_DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [WIDTH-1:0] mem [SKID_DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Full when the pointers differ only in the wrap bit; empty when equal.
    always_comb begin
        full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        empty    = (wr_ptr == rd_ptr);
        count    = wr_ptr - rd_ptr;
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        pop_data = mem[rd_ptr[AW-1:0]];
    end

    // Pointer update; pointers wrap naturally through the extra bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Storage write; contents need no reset since empty masks them.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/ft232h_rx.sv
// FT232H synchronous 245 FIFO receiver: sequences OE#/RD# from RXF# and the
// arbiter grant, captures bytes into a skid FIFO and presents them on AXIS.
module ft232h_rx
    import ft232h_pkg::*;
#(
    parameter int unsigned SKID_DEPTH = 4
) (
    input  logic                       ftdi_clk,
    input  logic                       rst,
    input  logic                       ftdi_rxf_n,
    input  logic [FTDI_DATA_WIDTH-1:0] ftdi_data_in,
    output logic                       ftdi_oe_n,
    output logic                       ftdi_rd_n,
    input  logic                       rx_enable,
    output logic                       rx_busy,
    output logic                       overflow_err,
    axis_io.Source                     host_axis
);

    localparam int unsigned AW = $clog2(SKID_DEPTH);
    localparam logic [AW:0] CNT_ONE   = (AW+1)'(1);
    localparam logic [AW:0] SPACE_MAX = (AW+1)'(SKID_DEPTH - 2);

    ftdi_rx_state_t       state;
    ftdi_rx_state_t       state_next;
    logic                 oe_next;
    logic                 rd_next;

    logic                 push;
    logic                 pop;
    logic                 push_ok;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [AW:0]          fifo_count;
    logic [AW:0]          count_n;
    logic                 space;
    logic [FTDI_DATA_WIDTH-1:0] fifo_data;

    ft232h_skid_fifo #(
        .SKID_DEPTH (SKID_DEPTH),
        .WIDTH      (FTDI_DATA_WIDTH)
    ) u_skid (
        .clk       (ftdi_clk),
        .rst       (rst),
        .push      (push),
        .push_data (ftdi_data_in),
        .pop       (pop),
        .pop_data  (fifo_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Capture/pop strobes and the post-update occupancy used by the space rule.
    // count_n already includes this cycle's capture, so RD# is released early
    // enough to absorb the byte that arrives during its registered lag.
    always_comb begin
        push    = !ftdi_rd_n && !ftdi_rxf_n;
        pop     = host_axis.tready && !fifo_empty;
        push_ok = push && (!fifo_full || pop);
        count_n = fifo_count;
        if (push_ok && !pop) begin
            count_n = fifo_count + CNT_ONE;
        end else if (!push_ok && pop) begin
            count_n = fifo_count - CNT_ONE;
        end
        space = (count_n <= SPACE_MAX);
    end

    // Next-state and next registered FTDI strobes.
    always_comb begin
        state_next = state;
        oe_next    = ftdi_oe_n;
        rd_next    = ftdi_rd_n;
        case (state)
            IDLE: begin
                if (rx_enable && !ftdi_rxf_n && space) begin
                    oe_next    = 1'b0;
                    state_next = TURN;
                end
            end
            TURN: begin
                if (!ftdi_rxf_n && space) begin
                    rd_next    = 1'b0;
                    state_next = READ;
                end else begin
                    oe_next    = 1'b1;
                    state_next = IDLE;
                end
            end
            READ: begin
                if (ftdi_rxf_n || !space || !rx_enable) begin
                    rd_next    = 1'b1;
                    oe_next    = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                rd_next    = 1'b1;
                oe_next    = 1'b1;
                state_next = IDLE;
            end
        endcase
    end

    // State, registered strobes and sticky overflow flag.
    always_ff @(posedge ftdi_clk) begin
        if (rst) begin
            state        <= IDLE;
            ftdi_oe_n    <= 1'b1;
            ftdi_rd_n    <= 1'b1;
            overflow_err <= 1'b0;
        end else begin
            state     <= state_next;
            ftdi_oe_n <= oe_next;
            ftdi_rd_n <= rd_next;
            if (push && fifo_full && !pop) overflow_err <= 1'b1;
        end
    end

    // Status and stream outputs.
    always_comb begin
        rx_busy          = (state != IDLE);
        host_axis.tvalid = !fifo_empty;
        host_axis.tdata  = fifo_data;
        host_axis.tlast  = 1'b0;
    end

endmodule

// File: tb/tb_ft232h_rx.sv
// Self-checking bench for ft232h_rx: FT232H host model, ordered-stream
// scoreboard, per-cycle table for the first burst and directed corner cases.
module tb_ft232h_rx;

    localparam int SKID_DEPTH = 4;

    logic       ftdi_clk = 1'b0;
    logic       rst;
    logic       ftdi_rxf_n;
    logic [7:0] ftdi_data_in;
    logic       ftdi_oe_n;
    logic       ftdi_rd_n;
    logic       rx_enable;
    logic       rx_busy;
    logic       overflow_err;

    axis_io #(.W(8)) host_axis_if ();

    ft232h_rx #(.SKID_DEPTH(SKID_DEPTH)) dut (
        .ftdi_clk     (ftdi_clk),
        .rst          (rst),
        .ftdi_rxf_n   (ftdi_rxf_n),
        .ftdi_data_in (ftdi_data_in),
        .ftdi_oe_n    (ftdi_oe_n),
        .ftdi_rd_n    (ftdi_rd_n),
        .rx_enable    (rx_enable),
        .rx_busy      (rx_busy),
        .overflow_err (overflow_err),
        .host_axis    (host_axis_if)
    );

    always #5 ftdi_clk = ~ftdi_clk;

    int total = 0;
    int bad   = 0;

    logic [7:0] host_q[$];   // bytes the host still holds
    logic [7:0] exp_q[$];    // bytes handed over, not yet delivered
    bit         host_on = 1'b0;
    int         released = 0;
    int         received = 0;

    typedef struct {
        logic       rx_en;
        logic       tready;
        logic       oe_n;
        logic       rd_n;
        logic       busy;
        logic       tvalid;
        logic       chk_data;
        logic [7:0] tdata;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
        end
    endtask

    // FT232H host: a byte is consumed on every edge where RD# and RXF# are low.
    initial begin
        bit cap;
        ftdi_rxf_n   = 1'b1;
        ftdi_data_in = 8'h00;
        forever begin
            @(posedge ftdi_clk);
            cap = !rst && !ftdi_rd_n && !ftdi_rxf_n;
            #1;
            if (cap) begin
                exp_q.push_back(host_q.pop_front());
                released++;
            end
            ftdi_rxf_n   = !(host_on && host_q.size() > 0);
            ftdi_data_in = (host_q.size() > 0) ? host_q[0] : 8'h00;
        end
    end

    // Stream sink: every accepted byte must be the oldest outstanding one.
    initial begin
        logic [7:0] got;
        forever begin
            @(posedge ftdi_clk);
            if (!rst && host_axis_if.tvalid && host_axis_if.tready) begin
                got = host_axis_if.tdata;
                received++;
                if (exp_q.size() == 0) begin
                    check("unexpected_byte", {24'h0, got}, 32'hFFFF_FFFF);
                end else begin
                    check("stream", {24'h0, got}, {24'h0, exp_q.pop_front()});
                end
            end
        end
    end

    // Per-cycle invariants against the outstanding-byte model.
    initial begin
        forever begin
            @(negedge ftdi_clk);
            if (!rst) begin
                check("occupancy_le_depth_m1", (exp_q.size() <= SKID_DEPTH - 1), 1);
                check("tvalid_vs_model", host_axis_if.tvalid, (exp_q.size() != 0));
                if (exp_q.size() != 0 && host_axis_if.tvalid)
                    check("head_data", host_axis_if.tdata, exp_q[0]);
                check("rd_implies_oe", (!ftdi_rd_n && ftdi_oe_n), 0);
                check("tlast_zero", host_axis_if.tlast, 0);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while ((host_q.size() != 0 || exp_q.size() != 0) && n < budget) begin
            @(negedge ftdi_clk);
            n++;
        end
        check(name, (n < budget), 1);
    endtask

    task automatic wait_released(input string name, input int target, input int budget);
        int n = 0;
        while (released < target && n < budget) begin
            @(negedge ftdi_clk);
            n++;
        end
        check(name, (n < budget), 1);
    endtask

    task automatic check_idle_outputs(input string name);
        check(name, {ftdi_oe_n, ftdi_rd_n, rx_busy, host_axis_if.tvalid}, 4'b1100);
    endtask

    initial begin
        int rel0;
        int rcv0;
        int n;

        // Expected waveform of an 8-byte burst, one row per cycle after edge k.
        for (int k = 0; k < 13; k++) begin
            vecs[k].rx_en    = 1'b1;
            vecs[k].tready   = 1'b1;
            vecs[k].chk_data = 1'b0;
            vecs[k].tdata    = 8'h00;
            vecs[k].tvalid   = 1'b0;
            if (k == 0 || k >= 11) begin
                vecs[k].oe_n = 1'b1; vecs[k].rd_n = 1'b1; vecs[k].busy = 1'b0;
            end else if (k == 1) begin
                vecs[k].oe_n = 1'b0; vecs[k].rd_n = 1'b1; vecs[k].busy = 1'b1;
            end else begin
                vecs[k].oe_n = 1'b0; vecs[k].rd_n = 1'b0; vecs[k].busy = 1'b1;
            end
            if (k >= 3 && k <= 10) begin
                vecs[k].tvalid   = 1'b1;
                vecs[k].chk_data = 1'b1;
                vecs[k].tdata    = 8'h10 + 8'(k - 3);
            end
        end

        rst = 1'b1;
        rx_enable = 1'b0;
        host_axis_if.tready = 1'b0;
        repeat (3) @(negedge ftdi_clk);
        check_idle_outputs("reset_outputs");
        check("reset_overflow", overflow_err, 0);
        rst = 1'b0;
        @(negedge ftdi_clk);

        // Burst without backpressure, checked cycle by cycle.
        rx_enable = 1'b1;
        host_axis_if.tready = 1'b1;
        for (int i = 0; i < 8; i++) host_q.push_back(8'h10 + 8'(i));
        host_on = 1'b1;
        for (int k = 0; k < 13; k++) begin
            @(negedge ftdi_clk);
            rx_enable = vecs[k].rx_en;
            host_axis_if.tready = vecs[k].tready;
            check($sformatf("burst_oe_n[%0d]", k), ftdi_oe_n, vecs[k].oe_n);
            check($sformatf("burst_rd_n[%0d]", k), ftdi_rd_n, vecs[k].rd_n);
            check($sformatf("burst_busy[%0d]", k), rx_busy, vecs[k].busy);
            check($sformatf("burst_tvalid[%0d]", k), host_axis_if.tvalid, vecs[k].tvalid);
            if (vecs[k].chk_data)
                check($sformatf("burst_tdata[%0d]", k), host_axis_if.tdata, vecs[k].tdata);
        end
        check("burst_bytes", received, 8);
        check("burst_overflow", overflow_err, 0);

        // Empty host: nothing may move.
        for (int c = 0; c < 100; c++) begin
            @(negedge ftdi_clk);
            check_idle_outputs("empty_host");
        end

        // Backpressure: only SKID_DEPTH-1 bytes may be taken, then drain.
        rel0 = released;
        rcv0 = received;
        host_axis_if.tready = 1'b0;
        for (int i = 0; i < 10; i++) host_q.push_back(8'h20 + 8'(i));
        repeat (20) @(negedge ftdi_clk);
        check("bp_rd_n_high", ftdi_rd_n, 1);
        check("bp_oe_n_high", ftdi_oe_n, 1);
        check("bp_taken", released - rel0, SKID_DEPTH - 1);
        host_axis_if.tready = 1'b1;
        wait_drain("bp_drain_timeout", 500);
        check("bp_delivered", received - rcv0, 10);
        check("bp_overflow", overflow_err, 0);

        // Grant removal after three bytes.
        rel0 = released;
        rcv0 = received;
        for (int i = 0; i < 8; i++) host_q.push_back(8'h30 + 8'(i));
        wait_released("grant_wait_timeout", rel0 + 3, 200);
        rx_enable = 1'b0;
        @(negedge ftdi_clk);
        check("grant_rd_n_high", ftdi_rd_n, 1);
        check("grant_oe_n_high", ftdi_oe_n, 1);
        host_on = 1'b0;
        repeat (5) @(negedge ftdi_clk);
        check("grant_taken", released - rel0, 4);
        check("grant_delivered", received - rcv0, 4);
        host_q.delete();
        rx_enable = 1'b1;
        host_on = 1'b1;

        // Reset in READ with two bytes buffered.
        rel0 = released;
        host_axis_if.tready = 1'b0;
        for (int i = 0; i < 6; i++) host_q.push_back(8'h40 + 8'(i));
        wait_released("rst_wait_timeout", rel0 + 2, 200);
        check("rst_in_read", {ftdi_oe_n, ftdi_rd_n}, 2'b00);
        rst = 1'b1;
        @(negedge ftdi_clk);
        check_idle_outputs("rst_mid_read");
        check("rst_no_capture", released - rel0, 2);
        host_q.delete();
        exp_q.delete();
        @(negedge ftdi_clk);
        rst = 1'b0;
        rcv0 = received;
        host_axis_if.tready = 1'b1;
        host_q.push_back(8'hA5);
        host_q.push_back(8'h5A);
        wait_drain("post_rst_timeout", 200);
        check("post_rst_delivered", received - rcv0, 2);

        // Random traffic with random tready/grant/availability.
        rcv0 = received;
        for (int i = 0; i < 100; i++) host_q.push_back(8'($urandom_range(0, 255)));
        n = 0;
        while ((host_q.size() != 0 || exp_q.size() != 0) && n < 5000) begin
            @(negedge ftdi_clk);
            host_axis_if.tready = 1'($urandom_range(0, 1));
            host_on   = ($urandom_range(0, 3) != 0);
            rx_enable = ($urandom_range(0, 7) != 0);
            n++;
        end
        check("random_timeout", (n < 5000), 1);
        check("random_delivered", received - rcv0, 100);
        check("final_overflow", overflow_err, 0);

        host_axis_if.tready = 1'b1;
        repeat (3) @(negedge ftdi_clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
